// File: rtl/irq_ctrl_pkg.sv
// Shared interrupt-controller types: FSM states, register offsets, CUR bit positions.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_t;

  localparam logic [2:0] IRQ_REG_PEND = 3'd0;
  localparam logic [2:0] IRQ_REG_MASK = 3'd1;
  localparam logic [2:0] IRQ_REG_CUR  = 3'd2;
  localparam logic [2:0] IRQ_REG_EOI  = 3'd3;
  localparam logic [2:0] IRQ_REG_EDGE = 3'd4;

  localparam int IRQ_CUR_VALID = 31;
  localparam int IRQ_CUR_SPUR  = 30;
  localparam int IRQ_ID_W      = 5;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, pure combinational.
module irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic               any_o,
  output logic [4:0]         id_o
);

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    id_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (vec_i[i]) id_o = 5'(i);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes NUM_SRC lines, keeps PEND/MASK, presents one
// prioritized request on irq, captures the acked ID into CUR and waits for EOI.
// Build option: IRQ_CTRL_EDGE_EN enables the per-source EDGE register (edge/level select);
// without it every source is level-sensitive.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  input  logic               irq_ack,
  input  logic               bus_sel,
  input  logic               bus_we,
  input  logic [2:0]         bus_addr,
  input  logic [DATA_W-1:0]  bus_wdata,
  output logic [DATA_W-1:0]  bus_rdata
);

  logic [NUM_SRC-1:0] s1_q, s2_q, pend_q, pend_d, mask_q, elig, win_oh;
  logic [DATA_W-1:0]  rdata_q, rd_d;
  logic [4:0]         win_id, cur_id_q;
  logic               elig_any, cur_valid_q, cur_spur_q;
  logic               wr, rd, eoi_wr, eoi_fire, cap_req, cap_spur;
  irq_state_t         state_q, state_d;

  assign wr       = bus_sel & bus_we;
  assign rd       = bus_sel & ~bus_we;
  assign eoi_wr   = wr && (bus_addr == IRQ_REG_EOI);
  assign eoi_fire = eoi_wr && (state_q == IRQ_SVC);
  assign elig     = pend_q & mask_q;
  assign win_oh   = NUM_SRC'(1) << win_id;
  assign irq      = (state_q == IRQ_REQ);
  assign bus_rdata = rdata_q;

  irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .vec_i (elig),
    .any_o (elig_any),
    .id_o  (win_id)
  );

  // Two-flop synchronizer on every source line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= irq_src;
      s2_q <= s1_q;
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] s3_q, edge_q, w1c, ack_clr, rise;

  assign w1c     = (wr && bus_addr == IRQ_REG_PEND) ? (bus_wdata[NUM_SRC-1:0] & edge_q) : '0;
  assign ack_clr = cap_req ? (win_oh & edge_q) : '0;
  assign rise    = s2_q & ~s3_q & edge_q;
  // Edge bits: a fresh edge beats any same-cycle clear; level bits mirror s2.
  assign pend_d  = (edge_q & (rise | (pend_q & ~(w1c | ack_clr)))) | (~edge_q & s2_q);

  // Edge-detect delay flop and the edge/level select register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_q   <= '0;
      edge_q <= '0;
    end else begin
      s3_q <= s2_q;
      if (wr && bus_addr == IRQ_REG_EDGE) edge_q <= bus_wdata[NUM_SRC-1:0];
    end
  end
`else
  logic [NUM_SRC-1:0] unused_oh;
  assign unused_oh = win_oh;
  assign pend_d    = s2_q;
`endif

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[DATA_W-1:NUM_SRC];

  // Pending and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      mask_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (wr && bus_addr == IRQ_REG_MASK) mask_q <= bus_wdata[NUM_SRC-1:0];
    end
  end

  // Request FSM; an ack always wins over a same-cycle withdrawal.
  always_comb begin
    state_d  = state_q;
    cap_req  = 1'b0;
    cap_spur = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (irq_ack) begin
          cap_spur = 1'b1;
          state_d  = IRQ_SVC;
        end else if (elig_any) begin
          state_d = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (irq_ack) begin
          cap_req = 1'b1;
          state_d = IRQ_SVC;
        end else if (!elig_any) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SVC:  if (eoi_wr) state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  // State and captured-ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IRQ_IDLE;
      cur_valid_q <= 1'b0;
      cur_spur_q  <= 1'b0;
      cur_id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cap_req) begin
        cur_valid_q <= 1'b1;
        cur_spur_q  <= 1'b0;
        cur_id_q    <= win_id;
      end else if (cap_spur) begin
        cur_valid_q <= 1'b1;
        cur_spur_q  <= 1'b1;
        cur_id_q    <= '0;
      end else if (eoi_fire) begin
        cur_valid_q <= 1'b0;
      end
    end
  end

  // Read mux; unmapped and write-only offsets return 0.
  always_comb begin
    rd_d = '0;
    case (bus_addr)
      IRQ_REG_PEND: rd_d[NUM_SRC-1:0] = pend_q;
      IRQ_REG_MASK: rd_d[NUM_SRC-1:0] = mask_q;
      IRQ_REG_CUR: begin
        rd_d[IRQ_CUR_VALID]  = cur_valid_q;
        rd_d[IRQ_CUR_SPUR]   = cur_spur_q;
        rd_d[IRQ_ID_W-1:0]   = cur_id_q;
      end
`ifdef IRQ_CTRL_EDGE_EN
      IRQ_REG_EDGE: rd_d[NUM_SRC-1:0] = edge_q;
`endif
      default: rd_d = '0;
    endcase
  end

  // Registered read data, updated only by a read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (rd) rdata_q <= rd_d;
  end

endmodule
